// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration path: sequencer states,
// counter widths and the index-to-one-hot helper also used by row frame data.
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } cfg_state_e;

    localparam int unsigned PHASE_CNT_W  = 4;
    localparam int unsigned STROBE_CNT_W = 16;
    localparam int unsigned ONEHOT_MAX_W = 64;

    // Returns all-zero when idx is outside 0..n_bits-1, so callers can reduce-OR
    // the result to recover the in-range flag.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot_idx(input int unsigned idx,
                                                           input int unsigned n_bits);
        logic [ONEHOT_MAX_W-1:0] vec;
        vec = '0;
        if (idx < n_bits && idx < ONEHOT_MAX_W)
            vec = ONEHOT_MAX_W'(1) << idx;
        return vec;
    endfunction

endpackage

// File: rtl/frame_strobe_decode.sv
// Combinational frame index to one-hot strobe pattern, with an in-range flag
// for indices at or beyond the column's frame count.
module frame_strobe_decode
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5
) (
    input  logic [FrameSelectWidth-1:0] frame,
    output logic [MaxFramesPerCol-1:0]  onehot,
    output logic                        in_range
);

    logic [ONEHOT_MAX_W-1:0] full_vec;

    always_comb begin
        full_vec = onehot_idx(32'(frame), MaxFramesPerCol);
        onehot   = full_vec[MaxFramesPerCol-1:0];
        in_range = |full_vec;
    end

endmodule

// File: rtl/frame_strobe_gen.sv
// Per-column frame strobe sequencer: accepts broadcast frame-write commands and
// runs SETUP/STROBE/HOLD in lockstep with every other column; only the addressed one pulses.
module frame_strobe_gen
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned ColSelectWidth   = 5,
    parameter int unsigned ColumnId         = 0,
    parameter int unsigned SetupCycles      = 1,
    parameter int unsigned StrobeCycles     = 1,
    parameter int unsigned HoldCycles       = 1
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ColSelectWidth-1:0]   cmd_col,
    input  logic [FrameSelectWidth-1:0] cmd_frame,
    input  logic                        abort,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [STROBE_CNT_W-1:0]     strobe_cnt
);

    cfg_state_e               state, state_next;
    logic [PHASE_CNT_W-1:0]   phase_cnt;
    logic [MaxFramesPerCol-1:0] strobe_pat;
    logic [MaxFramesPerCol-1:0] dec_onehot;
    logic [STROBE_CNT_W-1:0]  strobe_count;
    logic                     dec_in_range;
    logic                     col_match;
    logic                     accept;
    logic                     phase_last;
    logic                     enter_strobe;

    frame_strobe_decode #(
        .MaxFramesPerCol  (MaxFramesPerCol),
        .FrameSelectWidth (FrameSelectWidth)
    ) u_decode (
        .frame    (cmd_frame),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    assign col_match    = (cmd_col == ColSelectWidth'(ColumnId));
    assign accept       = cmd_valid && (state == ST_IDLE);
    assign phase_last   = (phase_cnt == '0);
    assign enter_strobe = (state == ST_SETUP) && (state_next == ST_STROBE);

    // NOTE: registers take <= so every flop samples pre-edge values; blocking here would race.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Abort outranks phase expiry in every busy state; IDLE ignores it.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            ST_IDLE:   if (accept)          state_next = ST_SETUP;
            ST_SETUP:  if (abort)           state_next = ST_IDLE;
                       else if (phase_last) state_next = ST_STROBE;
            ST_STROBE: if (abort)           state_next = ST_IDLE;
                       else if (phase_last) state_next = ST_HOLD;
            ST_HOLD:   if (abort)           state_next = ST_IDLE;
                       else if (phase_last) state_next = ST_IDLE;
        endcase
    end

    // NOTE: every datapath flop is reset too, so a mid-sequence reset drops FrameStrobe at once.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            phase_cnt    <= '0;
            strobe_pat   <= '0;
            FrameStrobe  <= '0;
            strobe_count <= '0;
            err          <= 1'b0;
        end else begin
            err <= accept && col_match && !dec_in_range;
            if (accept)
                strobe_pat <= (col_match && dec_in_range) ? dec_onehot : '0;

            if (state_next != state) begin
                case (state_next)
                    ST_SETUP:  phase_cnt <= PHASE_CNT_W'(SetupCycles - 1);
                    ST_STROBE: phase_cnt <= PHASE_CNT_W'(StrobeCycles - 1);
                    ST_HOLD:   phase_cnt <= PHASE_CNT_W'(HoldCycles - 1);
                    default:   phase_cnt <= '0;
                endcase
            end else if (!phase_last) begin
                phase_cnt <= phase_cnt - 1'b1;
            end

            if (enter_strobe)
                FrameStrobe <= strobe_pat;
            else if (state_next != ST_STROBE)
                FrameStrobe <= '0;

            if (enter_strobe && |strobe_pat)
                strobe_count <= strobe_count + 1'b1;
        end
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        done      = (state == ST_HOLD) && phase_last;
    end

    assign strobe_cnt = strobe_count;

endmodule

// File: tb/tb_frame_strobe_gen.sv
// Directed bench for frame_strobe_gen: one instance with default timing and one
// with stretched phases, both answering to column 3.
module tb_frame_strobe_gen;

    logic        CLK = 1'b0;
    logic        resetn;

    logic        a_cmd_valid, a_cmd_ready, a_abort, a_busy, a_done, a_err;
    logic [4:0]  a_cmd_col, a_cmd_frame;
    logic [19:0] a_fs;
    logic [15:0] a_strobe_cnt;

    logic        b_cmd_valid, b_cmd_ready, b_abort, b_busy, b_done, b_err;
    logic [4:0]  b_cmd_col, b_cmd_frame;
    logic [19:0] b_fs;
    logic [15:0] b_strobe_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        done_seen;
    int          acc_q[$];

    always #5 CLK = ~CLK;

    frame_strobe_gen #(
        .ColumnId (3)
    ) dut_a (
        .CLK         (CLK),
        .resetn      (resetn),
        .cmd_valid   (a_cmd_valid),
        .cmd_ready   (a_cmd_ready),
        .cmd_col     (a_cmd_col),
        .cmd_frame   (a_cmd_frame),
        .abort       (a_abort),
        .FrameStrobe (a_fs),
        .busy        (a_busy),
        .done        (a_done),
        .err         (a_err),
        .strobe_cnt  (a_strobe_cnt)
    );

    frame_strobe_gen #(
        .ColumnId     (3),
        .SetupCycles  (2),
        .StrobeCycles (3),
        .HoldCycles   (2)
    ) dut_b (
        .CLK         (CLK),
        .resetn      (resetn),
        .cmd_valid   (b_cmd_valid),
        .cmd_ready   (b_cmd_ready),
        .cmd_col     (b_cmd_col),
        .cmd_frame   (b_cmd_frame),
        .abort       (b_abort),
        .FrameStrobe (b_fs),
        .busy        (b_busy),
        .done        (b_done),
        .err         (b_err),
        .strobe_cnt  (b_strobe_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // After the edge: the bench then sits in cycle k+1 for edge k.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic a_issue(input logic [4:0] col, input logic [4:0] frame);
        a_cmd_valid = 1'b1;
        a_cmd_col   = col;
        a_cmd_frame = frame;
        tick();
        a_cmd_valid = 1'b0;
    endtask

    task automatic b_issue(input logic [4:0] col, input logic [4:0] frame);
        b_cmd_valid = 1'b1;
        b_cmd_col   = col;
        b_cmd_frame = frame;
        tick();
        b_cmd_valid = 1'b0;
    endtask

    task automatic a_wait_idle();
        int n = 0;
        while (a_busy && n < 50) begin
            tick();
            n++;
        end
        check("a_idle_timeout", 32'(a_busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_col = '0; a_cmd_frame = '0; a_abort = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_col = '0; b_cmd_frame = '0; b_abort = 1'b0;
        tick();
        tick();

        check("rst_ready",  32'(a_cmd_ready),  32'h1);
        check("rst_fs",     32'(a_fs),         32'h0);
        check("rst_busy",   32'(a_busy),       32'h0);
        check("rst_done",   32'(a_done),       32'h0);
        check("rst_err",    32'(a_err),        32'h0);
        check("rst_cnt",    32'(a_strobe_cnt), 32'h0);
        check("rst_b_ready", 32'(b_cmd_ready), 32'h1);
        resetn = 1'b1;
        tick();

        // Hit on column 3, frame 7, default 1/1/1 timing
        a_issue(5'd3, 5'd7);
        check("t1_c1_fs",    32'(a_fs),        32'h0);
        check("t1_c1_busy",  32'(a_busy),      32'h1);
        check("t1_c1_ready", 32'(a_cmd_ready), 32'h0);
        check("t1_c1_err",   32'(a_err),       32'h0);
        tick();
        check("t1_c2_fs",    32'(a_fs),        32'h00080);
        check("t1_c2_done",  32'(a_done),      32'h0);
        tick();
        check("t1_c3_fs",    32'(a_fs),        32'h0);
        check("t1_c3_done",  32'(a_done),      32'h1);
        tick();
        check("t1_c4_ready", 32'(a_cmd_ready), 32'h1);
        check("t1_c4_done",  32'(a_done),      32'h0);
        check("t1_c4_cnt",   32'(a_strobe_cnt), 32'h1);

        // Other column: full sequence, no strobe
        a_issue(5'd4, 5'd7);
        check("t3_c1_err",   32'(a_err),       32'h0);
        tick();
        check("t3_c2_fs",    32'(a_fs),        32'h0);
        tick();
        check("t3_c3_done",  32'(a_done),      32'h1);
        tick();
        check("t3_c4_ready", 32'(a_cmd_ready), 32'h1);
        check("t3_c4_cnt",   32'(a_strobe_cnt), 32'h1);

        // Matching column, frame 25 out of range
        a_issue(5'd3, 5'd25);
        check("t3b_c1_err",  32'(a_err),       32'h1);
        tick();
        check("t3b_c2_fs",   32'(a_fs),        32'h0);
        check("t3b_c2_err",  32'(a_err),       32'h0);
        tick();
        check("t3b_c3_done", 32'(a_done),      32'h1);
        tick();
        check("t3b_c4_cnt",  32'(a_strobe_cnt), 32'h1);

        // Range boundary: 20 is first illegal, 19 is last legal
        a_issue(5'd3, 5'd20);
        check("bnd20_err",   32'(a_err),       32'h1);
        a_wait_idle();
        a_issue(5'd3, 5'd19);
        check("bnd19_err",   32'(a_err),       32'h0);
        tick();
        check("bnd19_fs",    32'(a_fs),        32'h80000);
        a_wait_idle();
        check("bnd19_cnt",   32'(a_strobe_cnt), 32'h2);

        // Abort coinciding with accept in IDLE: accept wins
        a_abort = 1'b1;
        a_issue(5'd5, 5'd0);
        a_abort = 1'b0;
        check("idle_abort_busy", 32'(a_busy), 32'h1);
        a_wait_idle();

        // Stretched timing 2/3/2, frame 19
        b_issue(5'd3, 5'd19);
        tick();
        check("t2_c2_fs",    32'(b_fs),        32'h0);
        for (int c = 3; c <= 5; c++) begin
            tick();
            check($sformatf("t2_c%0d_fs", c), 32'(b_fs), 32'h80000);
        end
        tick();
        check("t2_c6_fs",    32'(b_fs),        32'h0);
        check("t2_c6_done",  32'(b_done),      32'h0);
        tick();
        check("t2_c7_done",  32'(b_done),      32'h1);
        check("t2_c7_ready", 32'(b_cmd_ready), 32'h0);
        tick();
        check("t2_c8_ready", 32'(b_cmd_ready), 32'h1);
        check("t2_c8_cnt",   32'(b_strobe_cnt), 32'h1);

        // Abort during the first STROBE cycle
        b_issue(5'd3, 5'd5);
        tick();
        tick();
        check("ab_c3_fs",    32'(b_fs),        32'h20);
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        check("ab_c4_fs",    32'(b_fs),        32'h0);
        check("ab_c4_busy",  32'(b_busy),      32'h0);
        check("ab_c4_ready", 32'(b_cmd_ready), 32'h1);
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            done_seen = done_seen | b_done;
            tick();
        end
        check("ab_no_done",  32'(done_seen),   32'h0);
        check("ab_cnt",      32'(b_strobe_cnt), 32'h2);

        // Continuous cmd_valid: accepts exactly 8 cycles apart
        b_cmd_valid = 1'b1;
        b_cmd_col   = 5'd3;
        b_cmd_frame = 5'd0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (b_cmd_ready) acc_q.push_back(i);
        end
        b_cmd_valid = 1'b0;
        check("b2b_count", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) begin
            check("b2b_first",  32'(acc_q[0]),            32'd8);
            check("b2b_gap1",   32'(acc_q[1] - acc_q[0]), 32'd8);
            check("b2b_gap2",   32'(acc_q[2] - acc_q[1]), 32'd8);
        end
        check("b2b_cnt",     32'(b_strobe_cnt), 32'h5);

        // Asynchronous reset while strobing
        b_issue(5'd3, 5'd2);
        tick();
        tick();
        check("rs_pre_fs",   32'(b_fs),        32'h4);
        #2 resetn = 1'b0;
        #1;
        check("rs_async_fs",    32'(b_fs),        32'h0);
        check("rs_async_ready", 32'(b_cmd_ready), 32'h1);
        #3 resetn = 1'b1;
        tick();
        check("rs_ready",    32'(b_cmd_ready), 32'h1);
        check("rs_busy",     32'(b_busy),      32'h0);
        check("rs_cnt",      32'(b_strobe_cnt), 32'h0);
        check("rs_a_cnt",    32'(a_strobe_cnt), 32'h0);

        // Counter wrap from 0xFFFF
        force dut_a.strobe_count = 16'hFFFF;
        #1;
        release dut_a.strobe_count;
        a_issue(5'd3, 5'd0);
        check("wrap_c1_cnt", 32'(a_strobe_cnt), 32'hFFFF);
        tick();
        check("wrap_c2_fs",  32'(a_fs),        32'h1);
        check("wrap_c2_cnt", 32'(a_strobe_cnt), 32'h0);
        a_wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
